// File: rtl/mandel_fb_writer.sv
// Framebuffer write arbiter: queues Mandelbrot plot requests in a small FIFO and
// drains them to a ready/valid memory write port with registered outputs.
// Optional clear engine enabled with macro FB_CLEAR_EN; without it the block is
// a plain plot FIFO and clear_start is ignored.
module mandel_fb_writer #(
    parameter int unsigned WIDTH        = 320,
    parameter int unsigned HEIGHT       = 240,
    parameter int unsigned DEPTH        = 8,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  vga_x,
    input  logic [7:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    output logic [16:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        idle,
    output logic        overflow,
    output logic        oob
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [19:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic          in_range;
    logic [16:0]   plot_addr;
    logic          full;
    logic          pop;
    logic          push;
    logic          drain_mode;
    logic [AW-1:0] head_idx;
    logic          head_valid;
    logic [19:0]   head;

`ifdef FB_CLEAR_EN
    typedef enum logic {DRAIN, CLEAR} state_t;
    localparam logic [16:0] LAST_ADDR = 17'(WIDTH * HEIGHT - 1);
    state_t      state;
    logic [16:0] clr_cnt;
    assign drain_mode = (state == DRAIN);
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, CLEAR_COLOUR};
    assign drain_mode   = 1'b1;
`endif

    assign in_range  = (32'(vga_x) < WIDTH) && (32'(vga_y) < HEIGHT);
    assign plot_addr = 17'(32'(vga_y) * WIDTH + 32'(vga_x));
    assign full      = (count == (AW+1)'(DEPTH));
    // Only the FIFO head may be popped, and only while it owns the memory port.
    assign pop       = drain_mode && mem_we && mem_ready;
    assign push      = vga_plot && in_range && (!full || pop);

    // Head to present after this edge: skip past the entry being popped.
    assign head_idx   = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign head_valid = pop ? (count > (AW+1)'(1)) : (count != '0);
    assign head       = fifo_mem[head_idx];

    assign idle = drain_mode && (count == '0) && !mem_we;

    // FIFO storage, pointers and sticky drop flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            oob      <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {plot_addr, vga_colour};
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (vga_plot && !in_range) begin
                oob <= 1'b1;
            end
            if (vga_plot && in_range && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Port owner FSM with registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef FB_CLEAR_EN
            state   <= DRAIN;
            clr_cnt <= '0;
`endif
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else begin
`ifdef FB_CLEAR_EN
            case (state)
                DRAIN: begin
                    if (clear_start && idle) begin
                        state    <= CLEAR;
                        clr_cnt  <= '0;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_data <= CLEAR_COLOUR;
                    end else begin
                        mem_we <= head_valid;
                        if (head_valid) begin
                            {mem_addr, mem_data} <= head;
                        end
                    end
                end
                CLEAR: begin
                    if (mem_ready) begin
                        if (clr_cnt == LAST_ADDR) begin
                            // Hand the port back; queued plots follow immediately.
                            state   <= DRAIN;
                            clr_cnt <= '0;
                            mem_we  <= head_valid;
                            if (head_valid) begin
                                {mem_addr, mem_data} <= head;
                            end
                        end else begin
                            clr_cnt  <= clr_cnt + 17'd1;
                            mem_addr <= clr_cnt + 17'd1;
                        end
                    end
                end
                default: state <= DRAIN;
            endcase
`else
            mem_we <= head_valid;
            if (head_valid) begin
                {mem_addr, mem_data} <= head;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mandel_fb_writer.sv
// Randomised self-checking bench for mandel_fb_writer against a queue-based
// reference model. Define FB_CLEAR_EN to also exercise the clear engine.
module tb_mandel_fb_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [16:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        idle;
    logic        overflow;
    logic        oob;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending pixels in arrival order, whether the head is on the port.
    logic [19:0] q[$];
    bit          m_we;
    bit          m_ovf;
    bit          m_oob;

    mandel_fb_writer dut (
        .clk         (clk),
        .rst         (rst),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clear_start (clear_start),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .idle        (idle),
        .overflow    (overflow),
        .oob         (oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_plot(input int x, input int y, input int c);
        vga_plot   = 1'b1;
        vga_x      = 9'(x);
        vga_y      = 8'(y);
        vga_colour = 3'(c);
    endtask

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic cycle();
        bit pop;
        int sz;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_we  = 0;
            m_ovf = 0;
            m_oob = 0;
        end else begin
            sz  = q.size();
            pop = m_we && mem_ready;
            if (pop) void'(q.pop_front());
            if (vga_plot) begin
                if (int'(vga_x) >= 320 || int'(vga_y) >= 240) m_oob = 1;
                else if (sz < 8 || pop) q.push_back({17'(int'(vga_y) * 320 + int'(vga_x)), vga_colour});
                else m_ovf = 1;
            end
            // A pixel pushed on this edge is not visible on the port until the next one.
            m_we = pop ? (sz > 1) : (sz > 0);
        end
        #1;
        check("mem_we", mem_we, m_we);
        if (m_we) begin
            check("mem_addr", mem_addr, 32'(q[0][19:3]));
            check("mem_data", mem_data, 32'(q[0][2:0]));
        end
        check("idle", idle, (q.size() == 0 && !m_we));
        check("overflow", overflow, m_ovf);
        check("oob", oob, m_oob);
        if (rst) begin
            check("rst_addr", mem_addr, 0);
            check("rst_data", mem_data, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        mem_ready = 1'b1;
        vga_plot  = 1'b0;
        while (!(q.size() == 0 && !m_we) && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        rst = 1'b1; vga_plot = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0;
        clear_start = 1'b0; mem_ready = 1'b0;
        q.delete(); m_we = 0; m_ovf = 0; m_oob = 0;
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Single plot with ready high: one-cycle latency, then back to idle.
        mem_ready = 1'b1;
        set_plot(5, 2, 5);
        cycle();
        vga_plot = 1'b0;
        cycle();
        check("req035_addr", mem_addr, 645);
        check("req035_data", mem_data, 5);
        cycle();
        check("req035_idle", idle, 1);

        // Fill the FIFO with ready low, then a same-cycle pop and push at full.
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_plot(i * 7, i + 1, i);
            cycle();
        end
        mem_ready = 1'b1;
        set_plot(100, 200, 7);
        cycle();
        check("req038_occupancy", q.size(), 8);
        check("req038_no_ovf", overflow, 0);
        mem_ready = 1'b0;
        set_plot(1, 1, 1);
        cycle();
        check("req036_ovf", overflow, 1);
        drain("req036");

        // Out-of-range plots are dropped without touching the port.
        set_plot(320, 0, 3);
        cycle();
        set_plot(0, 240, 3);
        vga_plot = 1'b1;
        cycle();
        vga_plot = 1'b0;
        cycle();
        check("req037_oob", oob, 1);
        check("req037_idle", idle, 1);

        // Randomised traffic with occasional back-pressure bursts.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            vga_plot   = ($urandom_range(0, 99) < 60);
            vga_x      = 9'($urandom_range(0, 330));
            vga_y      = 8'($urandom_range(0, 245));
            vga_colour = 3'($urandom);
            mem_ready  = ((i / 64) % 3 == 2) ? ($urandom_range(0, 9) == 0)
                                             : ($urandom_range(0, 99) < 55);
            cycle();
        end
        drain("random");

        // Reset mid-transfer discards queued pixels.
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_plot(i, i, i);
            cycle();
        end
        vga_plot = 1'b0;
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

`ifdef FB_CLEAR_EN
        begin
            int nerr = 0;
            // Clear with one plot queued during the clear.
            check("clr_pre_idle", idle, 1);
            clear_start = 1'b1;
            @(posedge clk); #1;
            clear_start = 1'b0;
            set_plot(7, 1, 6);
            for (int i = 0; i < 76800; i++) begin
                if (mem_we !== 1'b1 || mem_addr !== 17'(i) || mem_data !== 3'b000) nerr++;
                @(posedge clk); #1;
                vga_plot = 1'b0;
            end
            check("clr_sweep_errors", nerr, 0);
            check("clr_plot_we", mem_we, 1);
            check("clr_plot_addr", mem_addr, 327);
            check("clr_plot_data", mem_data, 6);
            @(posedge clk); #1;
            check("clr_done_idle", idle, 1);
            check("clr_done_we", mem_we, 0);

            // Reset during a stalled clear with three queued plots.
            mem_ready   = 1'b0;
            clear_start = 1'b1;
            @(posedge clk); #1;
            clear_start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                set_plot(i + 10, 3, 2);
                @(posedge clk); #1;
            end
            vga_plot = 1'b0;
            check("clr_busy", idle, 0);
            do_reset();
            mem_ready = 1'b1;
            for (int i = 0; i < 6; i++) cycle();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
